rx_reset_sm: RTL and testbench

Per-channel RX reset sequencer for the ECP3 SERDES/PCS. It is the receive-side counterpart of the per-quad TX reset sequencer and runs on the same refclkdiv2 domain. The block holds the RX SERDES and RX PCS lane in reset until three conditions are met: the quad TX PLL is locked, a signal is present, and the CDR has stayed locked for a qualification interval. It then releases the PCS lane, and re-enters reset on any loss.

---
 rtl/rx_reset_sm_pkg.sv | 16 +
 rtl/rx_reset_sm_sync2ff.sv | 22 ++
 rtl/rx_reset_sm.sv | 126 ++++++++++++
 tb/tb_rx_reset_sm.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rx_reset_sm_pkg.sv
// Shared SERDES/PCS reset-sequencer encodings.
// Used by both the RX and the TX sequencers.
package rx_reset_sm_pkg;

  localparam int STATEWIDTH = 3;

  typedef enum logic [STATEWIDTH-1:0] {
    WAIT_FOR_PLOL   = 3'd0,
    RX_SERDES_RESET = 3'd1,
    WAIT_FOR_TIMER1 = 3'd2,
    CHECK_LOL_LOS   = 3'd3,
    WAIT_FOR_TIMER2 = 3'd4,
    NORMAL          = 3'd5
  } state_t;

endpackage

// File: rtl/rx_reset_sm_sync2ff.sv
// Two-flop synchroniser for a single async status bit.
// Resets to 1 so loss/lock flags read as "bad" until proven good.
module sync2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_reset_sm.sv
// Per-channel RX reset sequencer for the ECP3 SERDES/PCS.
// Holds SERDES/PCS in reset until PLL lock, signal and qualified CDR lock.
module rx_reset_sm
  import rx_reset_sm_pkg::*;
#(
  parameter int COUNT_INDEX  = 18,
  parameter int TIMER1_LIMIT = 4
) (
  input  logic refclkdiv2,
  input  logic rst_n,
  input  logic tx_pll_lol_qd_s,
  input  logic rx_cdr_lol_ch_s,
  input  logic rx_los_low_ch_s,
  output logic rx_serdes_rst_ch_c,
  output logic rx_pcs_rst_ch_c
);

  localparam logic [2:0] T1_MAX = 3'(TIMER1_LIMIT);

  logic plol_s;
  logic lol_s;
  logic los_s;
  logic lollos;

  state_t cs;
  state_t ns;

  logic [2:0]           counter1;
  logic [COUNT_INDEX:0] counter2;

  logic serdes_d;
  logic pcs_d;

  sync2ff u_sync_plol (
    .clk   (refclkdiv2),
    .rst_n (rst_n),
    .d     (tx_pll_lol_qd_s),
    .q     (plol_s)
  );

  sync2ff u_sync_lol (
    .clk   (refclkdiv2),
    .rst_n (rst_n),
    .d     (rx_cdr_lol_ch_s),
    .q     (lol_s)
  );

  sync2ff u_sync_los (
    .clk   (refclkdiv2),
    .rst_n (rst_n),
    .d     (rx_los_low_ch_s),
    .q     (los_s)
  );

  assign lollos = lol_s | los_s;

  always_ff @(posedge refclkdiv2) begin
    if (!rst_n) cs <= WAIT_FOR_PLOL;
    else        cs <= ns;
  end

  always_comb begin
    ns = cs;
    case (cs)
      WAIT_FOR_PLOL:
        if (!plol_s && !los_s) ns = RX_SERDES_RESET;
      RX_SERDES_RESET:
        ns = los_s ? WAIT_FOR_PLOL : WAIT_FOR_TIMER1;
      WAIT_FOR_TIMER1:
        if (los_s)                  ns = WAIT_FOR_PLOL;
        else if (counter1 == T1_MAX) ns = CHECK_LOL_LOS;
      CHECK_LOL_LOS:
        ns = los_s ? WAIT_FOR_PLOL : WAIT_FOR_TIMER2;
      WAIT_FOR_TIMER2:
        if (lollos)                     ns = CHECK_LOL_LOS;
        else if (counter2[COUNT_INDEX]) ns = NORMAL;
      NORMAL:
        if (lollos) ns = RX_SERDES_RESET;
      default:
        ns = WAIT_FOR_PLOL;
    endcase
    // PLL loss outranks every per-channel condition
    if (plol_s && cs != WAIT_FOR_PLOL) ns = WAIT_FOR_PLOL;
  end

  always_ff @(posedge refclkdiv2) begin
    if (!rst_n) begin
      counter1 <= '0;
      counter2 <= '0;
    end else begin
      if (cs == RX_SERDES_RESET)
        counter1 <= '0;
      else if (cs == WAIT_FOR_TIMER1 && counter1 != T1_MAX)
        counter1 <= counter1 + 3'd1;
      if (cs == CHECK_LOL_LOS)
        counter2 <= '0;
      else if (cs == WAIT_FOR_TIMER2 && !counter2[COUNT_INDEX])
        counter2 <= counter2 + 1'b1;
    end
  end

  always_comb begin
    serdes_d = 1'b1;
    pcs_d    = 1'b1;
    case (cs)
      CHECK_LOL_LOS,
      WAIT_FOR_TIMER2: serdes_d = 1'b0;
      NORMAL: begin
        serdes_d = 1'b0;
        pcs_d    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge refclkdiv2) begin
    if (!rst_n) begin
      rx_serdes_rst_ch_c <= 1'b1;
      rx_pcs_rst_ch_c    <= 1'b1;
    end else begin
      rx_serdes_rst_ch_c <= serdes_d;
      rx_pcs_rst_ch_c    <= pcs_d;
    end
  end

endmodule

// File: tb/tb_rx_reset_sm.sv
// Scoreboard bench for rx_reset_sm: expected reset levels are
// queued with a target cycle when stimulus is applied.
module tb_rx_reset_sm;
  import rx_reset_sm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic plol;
  logic cdr_lol;
  logic los;
  logic serdes_rst;
  logic pcs_rst;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    int    cyc;
    logic  s;
    logic  p;
    string tag;
  } exp_t;

  exp_t sb[$];

  rx_reset_sm #(
    .COUNT_INDEX  (4),
    .TIMER1_LIMIT (4)
  ) dut (
    .refclkdiv2         (clk),
    .rst_n              (rst_n),
    .tx_pll_lol_qd_s    (plol),
    .rx_cdr_lol_ch_s    (cdr_lol),
    .rx_los_low_ch_s    (los),
    .rx_serdes_rst_ch_c (serdes_rst),
    .rx_pcs_rst_ch_c    (pcs_rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic expect_at(input int rel, input logic s,
                           input logic p, input string tag);
    exp_t e;
    e.cyc = cyc + rel;
    e.s   = s;
    e.p   = p;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain", sb.size(), 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc <= cyc + 1;
    #1;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check({e.tag, "_serdes"}, 32'(serdes_rst), 32'(e.s));
      check({e.tag, "_pcs"}, 32'(pcs_rst), 32'(e.p));
    end
  end

  initial begin
    rst_n   = 1'b0;
    plol    = 1'b0;
    cdr_lol = 1'b0;
    los     = 1'b0;

    // reset, then clean bring-up
    tick(1);
    expect_at(1, 1, 1, "rst_a");
    expect_at(2, 1, 1, "rst_b");
    tick(2);
    rst_n = 1'b1;
    expect_at(9, 1, 1, "up_pre");
    expect_at(10, 0, 1, "up_serdes");
    expect_at(27, 0, 1, "up_pre_pcs");
    expect_at(28, 0, 0, "up_pcs");
    drain();

    // PLL unlocked after reset
    rst_n = 1'b0;
    plol  = 1'b1;
    tick(2);
    rst_n = 1'b1;
    expect_at(10, 1, 1, "plol_10");
    expect_at(28, 1, 1, "plol_28");
    expect_at(50, 1, 1, "plol_50");
    tick(50);
    plol = 1'b0;
    expect_at(9, 1, 1, "plol_pre");
    expect_at(10, 0, 1, "plol_serdes");
    expect_at(27, 0, 1, "plol_pre_pcs");
    expect_at(28, 0, 0, "plol_pcs");
    drain();

    // CDR glitch during qualification
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    expect_at(10, 0, 1, "q_entry");
    tick(18);
    cdr_lol = 1'b1;
    expect_at(3, 0, 1, "glitch_3");
    expect_at(10, 0, 1, "glitch_10");
    expect_at(23, 0, 1, "glitch_23");
    expect_at(24, 0, 0, "glitch_pcs");
    tick(3);
    cdr_lol = 1'b0;
    drain();

    // CDR loss in NORMAL
    cdr_lol = 1'b1;
    expect_at(3, 0, 0, "lol_3");
    expect_at(4, 1, 1, "lol_4");
    expect_at(9, 1, 1, "lol_9");
    expect_at(10, 0, 1, "lol_serdes");
    expect_at(27, 0, 1, "lol_27");
    expect_at(28, 0, 0, "lol_pcs");
    tick(1);
    cdr_lol = 1'b0;
    drain();

    // held LOS in NORMAL
    los = 1'b1;
    expect_at(3, 0, 0, "los_3");
    expect_at(4, 1, 1, "los_4");
    expect_at(12, 1, 1, "los_12");
    expect_at(20, 1, 1, "los_20");
    tick(20);
    los = 1'b0;
    expect_at(9, 1, 1, "los_pre");
    expect_at(10, 0, 1, "los_serdes");
    expect_at(27, 0, 1, "los_27");
    expect_at(28, 0, 0, "los_pcs");
    drain();

    // illegal state recovery
    force dut.cs = state_t'(3'd6);
    #1;
    release dut.cs;
    expect_at(1, 1, 1, "ill_1");
    expect_at(8, 1, 1, "ill_8");
    expect_at(9, 0, 1, "ill_serdes");
    expect_at(14, 0, 1, "ill_14");
    tick(1);
    check("ill_cs", 32'(dut.cs), 32'(WAIT_FOR_PLOL));
    tick(13);

    // one-cycle reset inside WAIT_FOR_TIMER2
    rst_n = 1'b0;
    expect_at(1, 1, 1, "mid_rst");
    tick(1);
    rst_n = 1'b1;
    expect_at(9, 1, 1, "mid_pre");
    expect_at(10, 0, 1, "mid_serdes");
    expect_at(27, 0, 1, "mid_27");
    expect_at(28, 0, 0, "mid_pcs");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
